parity_serializer: RTL and testbench
====================================

Name: parity_serializer

Overview:
- Transmit-side counterpart of the team's parity checker.
- Accepts a parallel word over a valid/ready handshake and computes its parity bit per the selected `parity_t` mode.
- Shifts out a UART-style serial frame: start bit, data LSB first, optional parity bit, stop bit(s).
- Sits between the packet/control logic and the serial pad; the remote receiver strips the frame and verifies parity.

Parameters:
- BITWIDTH, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- dataIn  input  BITWIDTH  parallel word to send.
- parityType  input  parity_t (parity_types_pkg)  EVEN/ODD/MARK/SPACE/NONE; sampled with dataIn.
- dataValid  input  1  dataIn/parityType valid.
- dataReady  output  1  block can accept a word.
- txOut  output  1  serial line; idle high.
- busy  output  1  frame in progress.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; txOut=1, busy=0, dataReady=1 (held while rst=1 and after release).
  - All counters and the shift register cleared.
  - Reset mid-frame aborts the frame immediately; the line returns to 1 with no glitch to 0.
- Handshake:
  - Transfer occurs on a rising edge with dataValid=1 and dataReady=1.
  - dataReady=1 only in IDLE.
  - dataValid while busy is ignored; the latched word is unaffected.
  - dataIn and parityType are captured at transfer and may change afterwards.
- Parity, computed at transfer from the captured data:
  - EVEN: p = XOR of all data bits, so total ones including p are even.
  - ODD: p = inverted XOR of all data bits.
  - MARK: p = 1. SPACE: p = 0.
  - NONE: no parity bit is sent.
  - Illegal encoding: parity bit sent as 0.
- State machine:
  - IDLE -> START on transfer.
  - START -> DATA.
  - DATA -> PARITY (or -> STOP if NONE) after BITWIDTH bits.
  - PARITY -> STOP.
  - STOP -> IDLE after STOP_BITS bits.
- Bit timing:
  - Each non-IDLE state bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter.
  - The baud counter resets to 0 on each bit boundary; it is $clog2(CLKS_PER_BIT) bits wide, min 1.
  - The bit index counter wraps to 0 on leaving DATA.
- Line levels:
  - START drives txOut=0. DATA drives the shift register LSB, shifting right once per bit. PARITY drives p. STOP drives 1.
  - txOut is registered; the first start-bit cycle is the cycle after transfer.
- busy is 1 from the cycle after transfer through the last STOP cycle; it equals (state != IDLE).
- Frame length is (1 + BITWIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, with P = 0 for NONE, else 1.
- Back-to-back: dataReady rises the cycle after the last stop cycle, giving a minimum of 1 idle cycle at txOut=1 between frames.
- Simultaneous rst and dataValid: reset wins and no transfer occurs.

Test Plan:
- EVEN framing (BITWIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1):
  - Stimulus: 0xA5, EVEN.
  - txOut bit sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 0, 1. That is 44 cycles.
  - busy high for exactly 44 cycles; dataReady low during the frame.
- ODD and NONE:
  - 0xA5 with ODD -> parity bit 1, frame 44 cycles.
  - 0x00 with NONE -> 0, eight 0s, 1: 40 cycles, no parity slot.
- MARK, SPACE, illegal:
  - 0xFF with MARK -> parity slot 1.
  - 0xFF with SPACE -> parity slot 0.
  - Illegal parityType value -> parity slot 0.
- Busy interaction:
  - Hold dataValid=1 with dataIn changing during a 0x3C EVEN frame.
  - Serial output must still be 0x3C with parity 0.
  - Second word accepted only after the idle cycle.
- Mid-frame reset:
  - Assert rst during DATA bit 3.
  - txOut=1, busy=0, dataReady=1 without waiting for a clock edge.
  - Next transfer after release produces a complete correct frame.
- STOP_BITS=2, CLKS_PER_BIT=2:
  - Stimulus: 0x01, EVEN.
  - Sequence: 0, 1,0,0,0,0,0,0,0, 1, 1,1 -> 24 cycles.

Source files
------------

// File: rtl/parity_types_pkg.sv
// Parity mode encodings shared by the parity checker and the parity serializer.
package parity_types_pkg;

    typedef enum logic [2:0] {
        EVEN  = 3'd0,
        ODD   = 3'd1,
        MARK  = 3'd2,
        SPACE = 3'd3,
        NONE  = 3'd4
    } parity_t;

endpackage

// File: rtl/parity_serializer.sv
// UART-style transmitter: latches a word over valid/ready and shifts out
// start, data (LSB first), optional parity and stop bits on a registered line.
module parity_serializer #(
    parameter int BITWIDTH     = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BITWIDTH-1:0]        dataIn,
    input  parity_types_pkg::parity_t  parityType,
    input  logic                       dataValid,
    output logic                       dataReady,
    output logic                       txOut,
    output logic                       busy
);

    localparam int BAUD_LOG = $clog2(CLKS_PER_BIT);
    localparam int CW       = (BAUD_LOG > 0) ? BAUD_LOG : 1;
    localparam int IDX_LOG  = $clog2(BITWIDTH);
    localparam int IW       = (IDX_LOG > 0) ? IDX_LOG : 1;

    localparam logic [CW-1:0] LAST_BAUD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(BITWIDTH - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state, stateNext;
    logic [CW-1:0]       baudCnt, baudNext;
    logic [IW-1:0]       bitIdx, bitNext;
    logic                stopCnt, stopNext;
    logic [BITWIDTH-1:0] shiftReg, shiftNext;
    logic                parityBit, parityBitNext;
    logic                parityEn, parityEnNext;
    logic                txNext;
    logic                baudDone;
    logic                newParity;

    always_comb begin
        unique case (parityType)
            parity_types_pkg::EVEN:  newParity = ^dataIn;
            parity_types_pkg::ODD:   newParity = ~(^dataIn);
            parity_types_pkg::MARK:  newParity = 1'b1;
            default:                 newParity = 1'b0;
        endcase
    end

    always_comb begin
        stateNext     = state;
        baudNext      = baudCnt;
        bitNext       = bitIdx;
        stopNext      = stopCnt;
        shiftNext     = shiftReg;
        parityBitNext = parityBit;
        parityEnNext  = parityEn;
        baudDone      = (baudCnt == LAST_BAUD);

        if (state != S_IDLE) begin
            baudNext = baudDone ? '0 : baudCnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (dataValid) begin
                    stateNext     = S_START;
                    shiftNext     = dataIn;
                    parityBitNext = newParity;
                    parityEnNext  = (parityType != parity_types_pkg::NONE);
                end
            end
            S_START: begin
                if (baudDone) stateNext = S_DATA;
            end
            S_DATA: begin
                if (baudDone) begin
                    shiftNext = shiftReg >> 1;
                    if (bitIdx == LAST_BIT) begin
                        bitNext   = '0;
                        stateNext = parityEn ? S_PARITY : S_STOP;
                    end else begin
                        bitNext = bitIdx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baudDone) stateNext = S_STOP;
            end
            S_STOP: begin
                if (baudDone) begin
                    if (stopCnt == LAST_STOP) begin
                        stopNext  = 1'b0;
                        stateNext = S_IDLE;
                    end else begin
                        stopNext = 1'b1;
                    end
                end
            end
            default: stateNext = S_IDLE;
        endcase

        // Line level is derived from the next state so txOut can be a plain register.
        case (stateNext)
            S_START:  txNext = 1'b0;
            S_DATA:   txNext = shiftNext[0];
            S_PARITY: txNext = parityBitNext;
            default:  txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            stopCnt   <= 1'b0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            parityEn  <= 1'b0;
            txOut     <= 1'b1;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudNext;
            bitIdx    <= bitNext;
            stopCnt   <= stopNext;
            shiftReg  <= shiftNext;
            parityBit <= parityBitNext;
            parityEn  <= parityEnNext;
            txOut     <= txNext;
        end
    end

    assign dataReady = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer: frame shapes per parity mode, busy
// interaction, mid-frame reset and a two-stop-bit configuration.
module tb_parity_serializer;

    import parity_types_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataIn;
    parity_t    parityType;
    logic       dataValid, dataValid2;
    logic       dataReady, txOut, busy;
    logic       dataReady2, txOut2, busy2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    parity_serializer #(.BITWIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .parityType(parityType),
        .dataValid(dataValid), .dataReady(dataReady), .txOut(txOut), .busy(busy)
    );

    parity_serializer #(.BITWIDTH(8), .CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .dataIn(dataIn), .parityType(parityType),
        .dataValid(dataValid2), .dataReady(dataReady2), .txOut(txOut2), .busy(busy2)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idleCheck(input string tag, input logic sel);
        check({tag, " idle tx"},    sel ? txOut2 : txOut, 1'b1);
        check({tag, " idle busy"},  sel ? busy2 : busy, 1'b0);
        check({tag, " idle ready"}, sel ? dataReady2 : dataReady, 1'b1);
    endtask

    // frame[k] is the k-th serial bit; each bit must hold for cpb cycles.
    task automatic runFrame(input string tag, input logic sel, input logic [7:0] data,
                            input parity_t pt, input logic [15:0] frame,
                            input int unsigned nbits, input int unsigned cpb,
                            input logic hold);
        @(negedge clk);
        idleCheck(tag, sel);
        dataIn     = data;
        parityType = pt;
        if (sel) dataValid2 = 1'b1;
        else     dataValid  = 1'b1;
        for (int unsigned i = 0; i < nbits * cpb; i++) begin
            @(negedge clk);
            check($sformatf("%s tx c%0d", tag, i),    sel ? txOut2 : txOut, frame[i / cpb]);
            check($sformatf("%s busy c%0d", tag, i),  sel ? busy2 : busy, 1'b1);
            check($sformatf("%s ready c%0d", tag, i), sel ? dataReady2 : dataReady, 1'b0);
            if (hold) begin
                dataIn = 8'($urandom);
            end else begin
                dataValid  = 1'b0;
                dataValid2 = 1'b0;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        dataIn     = '0;
        parityType = EVEN;
        dataValid  = 1'b0;
        dataValid2 = 1'b0;
        #1;
        idleCheck("reset", 1'b0);
        check("reset tx2", txOut2, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // {stop, parity, data, start}, transmitted from bit 0 upward
        runFrame("A5even",  1'b0, 8'hA5, EVEN,  {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0);
        runFrame("A5odd",   1'b0, 8'hA5, ODD,   {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4, 1'b0);
        runFrame("00none",  1'b0, 8'h00, NONE,  {6'b0, 1'b1, 8'h00, 1'b0},       10, 4, 1'b0);
        runFrame("FFmark",  1'b0, 8'hFF, MARK,  {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 4, 1'b0);
        runFrame("FFspace", 1'b0, 8'hFF, SPACE, {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11, 4, 1'b0);
        runFrame("FFillegal", 1'b0, 8'hFF, parity_t'(3'd5),
                 {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11, 4, 1'b0);

        // dataValid held high with a changing dataIn for the whole 0x3C frame
        runFrame("3Chold",  1'b0, 8'h3C, EVEN,  {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 4, 1'b1);
        runFrame("81next",  1'b0, 8'h81, EVEN,  {5'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 11, 4, 1'b0);
        @(negedge clk);
        idleCheck("81end", 1'b0);

        // Reset in the first cycle of data bit 3 (0xC3 bit 3 is 0)
        dataIn     = 8'hC3;
        parityType = EVEN;
        dataValid  = 1'b1;
        repeat (17) begin
            @(negedge clk);
            dataValid = 1'b0;
        end
        check("prerst tx", txOut, 1'b0);
        check("prerst busy", busy, 1'b1);
        #2;
        rst       = 1'b1;
        dataValid = 1'b1;
        #1;
        idleCheck("midrst", 1'b0);
        @(negedge clk);
        idleCheck("rstvalid", 1'b0);
        rst       = 1'b0;
        dataValid = 1'b0;
        runFrame("C3after", 1'b0, 8'hC3, EVEN, {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 4, 1'b0);
        @(negedge clk);
        idleCheck("C3end", 1'b0);

        runFrame("stop2", 1'b1, 8'h01, EVEN, {4'b0, 2'b11, 1'b1, 8'h01, 1'b0}, 12, 2, 1'b0);
        @(negedge clk);
        idleCheck("stop2end", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
